// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite word-addressed SRAM slave with programmable wait states and a two-cycle ERROR response.
// Define AHB_SLAVE_BURST_CHECK_EN to flag SEQ beats that break the burst address sequence.
module ahb_lite_sram_slave #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int unsigned STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB = $clog2(STRB_W);
    localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              wr_q, wr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [STRB_W-1:0] mask_q, mask_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  ready_int, accept, complete;
    logic                  size_err, align_err, range_err, acc_err;
    logic [ADDR_WIDTH-1:0] idx_full, align_mask;
    logic [STRB_W-1:0]     lane_mask;

    // Accepts are only taken while this slave is itself ready.
    assign ready_int  = (state_q != StWait) && (state_q != StErr1);
    assign accept     = HSEL && HREADY && HTRANS[1] && ready_int;
    assign complete   = (state_q == StIdle) && pend_q;

    assign idx_full   = HADDR >> ADDR_LSB;
    assign align_mask = (ADDR_WIDTH'(1) << HSIZE) - ADDR_WIDTH'(1);
    assign size_err   = HSIZE > 3'(ADDR_LSB);
    assign align_err  = (HADDR & align_mask) != '0;
    assign range_err  = idx_full >= ADDR_WIDTH'(DEPTH);

    always_comb begin
        int unsigned lane_off;
        int unsigned lane_cnt;
        lane_mask = '0;
        lane_off  = 32'(HADDR[ADDR_LSB-1:0]);
        lane_cnt  = 32'd1 << HSIZE;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            if (b >= lane_off && b < lane_off + lane_cnt) begin
                lane_mask[b] = 1'b1;
            end
        end
    end

`ifdef AHB_SLAVE_BURST_CHECK_EN
    logic                  bst_vld_q, bst_vld_d;
    logic [ADDR_WIDTH-1:0] bst_addr_q, bst_addr_d;
    logic [2:0]            bst_size_q, bst_size_d;
    logic [2:0]            bst_burst_q, bst_burst_d;
    logic [ADDR_WIDTH-1:0] step, wrap_bytes, incr_addr, exp_addr;
    logic                  seq_err;

    always_comb begin
        step = ADDR_WIDTH'(1) << bst_size_q;
        case (bst_burst_q)
            3'b010:  wrap_bytes = step << 2;
            3'b100:  wrap_bytes = step << 3;
            3'b110:  wrap_bytes = step << 4;
            default: wrap_bytes = '0;
        endcase
        incr_addr = bst_addr_q + step;
        if (wrap_bytes == '0) begin
            exp_addr = incr_addr;
        end else begin
            exp_addr = (bst_addr_q & ~(wrap_bytes - ADDR_WIDTH'(1)))
                     | (incr_addr & (wrap_bytes - ADDR_WIDTH'(1)));
        end
        seq_err = (HTRANS == 2'b11) && (!bst_vld_q || (HADDR != exp_addr));
    end

    assign acc_err = size_err | align_err | range_err | seq_err;

    // BUSY leaves the tracked beat untouched; IDLE or an ERROR breaks the burst.
    always_comb begin
        bst_vld_d   = bst_vld_q;
        bst_addr_d  = bst_addr_q;
        bst_size_d  = bst_size_q;
        bst_burst_d = bst_burst_q;
        if (accept) begin
            bst_vld_d   = !acc_err;
            bst_addr_d  = HADDR;
            bst_size_d  = HSIZE;
            bst_burst_d = HBURST;
        end else if (HSEL && HREADY && ready_int && (HTRANS == 2'b00)) begin
            bst_vld_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            bst_vld_q   <= 1'b0;
            bst_addr_q  <= '0;
            bst_size_q  <= '0;
            bst_burst_q <= '0;
        end else begin
            bst_vld_q   <= bst_vld_d;
            bst_addr_q  <= bst_addr_d;
            bst_size_q  <= bst_size_d;
            bst_burst_q <= bst_burst_d;
        end
    end
`else
    logic unused_burst;
    assign unused_burst = ^{HBURST, HTRANS[0]};
    assign acc_err      = size_err | align_err | range_err;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        unique case (state_q)
            StIdle, StErr2: begin
                state_d = StIdle;
                pend_d  = 1'b0;
                if (accept) begin
                    wr_d   = HWRITE;
                    idx_d  = idx_full[IDX_W-1:0];
                    mask_d = lane_mask;
                    if (acc_err) begin
                        state_d = StErr1;
                    end else if (WAIT_STATES == 0) begin
                        pend_d = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                    pend_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
        end
    end

    // Storage is deliberately not reset; a reset clears pend_q, which drops any pending write.
    always_ff @(posedge HCLK) begin
        if (complete && wr_q) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (mask_q[b]) begin
                    mem[idx_q][b*8 +: 8] <= HWDATA[b*8 +: 8];
                end
            end
        end
    end

    assign HREADYOUT = ready_int;
    assign HRESP     = ((state_q == StErr1) || (state_q == StErr2)) ? 2'b01 : 2'b00;
    assign HRDATA    = (complete && !wr_q) ? mem[idx_q] : '0;

endmodule
